// File: rtl/traffic_pkg.sv
// traffic_pkg: sensor channel map and default conditioning settings shared
// by the traffic controller and its input conditioning.
package traffic_pkg;
    localparam int N_CH              = 5;
    localparam int SNS_LEFT_MAIN     = 0;
    localparam int SNS_LEFT_CROSS    = 1;
    localparam int SNS_TRAFFIC_CROSS = 2;
    localparam int SNS_WALK_MAIN     = 3;
    localparam int SNS_WALK_CROSS    = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;
    localparam logic [N_CH-1:0] LATCH_MASK_DEF = 5'b11000;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: two-flop synchroniser, stability-counter debounce and
// registered rising-edge pulse for one sensor channel.
module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d, rise_q, rise_d;
    logic             differ, done;
    always_comb begin
        sync_d   = {sync_q[0], raw};
        differ   = sync_q[1] ^ stable_q;
        done     = differ && (cnt_q == LAST);
        stable_d = done ? sync_q[1] : stable_q;
        // any agreement with the current level restarts the stability window
        cnt_d    = (differ && !done) ? cnt_q + 1'b1 : '0;
        rise_d   = stable_d & ~stable_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end
    assign stable = stable_q;
    assign rise   = rise_q;
endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronises and debounces the raw sensor/button pins and
// holds walk requests until the controller acknowledges them.
module sensor_conditioner #(
    parameter int N_CH            = traffic_pkg::N_CH,
    parameter int DEBOUNCE_CYCLES = traffic_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = traffic_pkg::CNT_W_DEF,
    parameter logic [N_CH-1:0] LATCH_MASK = traffic_pkg::LATCH_MASK_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] raw_in,
    input  logic [N_CH-1:0] clear,
    output logic [N_CH-1:0] sensors,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] stable
);
    logic [N_CH-1:0] latch_q, latch_d;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (raw_in[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end
    // rise both shows the request at once and blocks a clear issued in that same cycle
    always_comb latch_d = LATCH_MASK & (rise | (latch_q & ~clear));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) latch_q <= '0;
        else          latch_q <= latch_d;
    end
    assign sensors = (stable & ~LATCH_MASK) | ((latch_q | rise) & LATCH_MASK);
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: scoreboarded random and directed stimulus against a
// sample-history reference model of the conditioning rules.
module tb_sensor_conditioner;
    import traffic_pkg::*;
    localparam int D = 4;
    localparam logic [4:0] MASK = LATCH_MASK_DEF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] raw_in = '0;
    logic [4:0] clear = '0;
    logic [4:0] sensors, rise, stable;

    sensor_conditioner #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(D), .CNT_W(3), .LATCH_MASK(MASK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .clear(clear),
        .sensors(sensors), .rise(rise), .stable(stable)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    bit          run = 1'b0;
    logic [14:0] exp_q[$];
    logic [4:0]  hist[$];
    logic [4:0]  m_stab = '0, m_rise = '0, m_pend = '0;

    // A level flips once the last D synchronised samples (raw delayed by two
    // clocks) all disagree with it; reset makes those samples zero.
    task automatic model(input logic rst, input logic [4:0] r, input logic [4:0] c);
        logic [4:0] ns, nr;
        bit all;
        if (!rst) begin
            hist = {};
            repeat (D + 2) hist.push_back(5'b0);
            m_stab = '0; m_rise = '0; m_pend = '0;
        end else begin
            hist.push_back(r);
            if (hist.size() > D + 2) void'(hist.pop_front());
            ns = m_stab;
            for (int i = 0; i < 5; i++) begin
                all = 1'b1;
                for (int j = 0; j < D; j++) if (hist[j][i] == m_stab[i]) all = 1'b0;
                if (all) ns[i] = ~m_stab[i];
            end
            nr = ns & ~m_stab;
            m_pend = (nr | m_rise | (m_pend & ~c)) & MASK;
            m_rise = nr;
            m_stab = ns;
        end
        exp_q.push_back({m_stab, m_rise, (m_stab & ~MASK) | m_pend});
        run = 1'b1;
    endtask

    task automatic step(input logic rst, input logic [4:0] r, input logic [4:0] c);
        @(negedge clk);
        reset_n = rst; raw_in = r; clear = c;
        model(rst, r, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        model(1'b0, raw_in, clear);
    endtask

    logic prev_rst = 1'b1;
    logic [14:0] e;
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n && prev_rst) begin
                #1 total++;
                if ({stable, rise, sensors} !== 15'b0) begin
                    bad++;
                    $display("FAIL async_reset t=%0t got stable=%b rise=%b sensors=%b want all zero",
                             $time, stable, rise, sensors);
                end
            end else begin
                #1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if ({stable, rise, sensors} !== e) begin
                        bad++;
                        $display("FAIL cycle_out t=%0t got stable=%b rise=%b sensors=%b want stable=%b rise=%b sensors=%b",
                                 $time, stable, rise, sensors, e[14:10], e[9:5], e[4:0]);
                    end
                end else if (run) begin
                    total++; bad++;
                    $display("FAIL no_expect t=%0t got none want one queued", $time);
                end
            end
            prev_rst = reset_n;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    logic [4:0] r;
    logic [4:0] tog;
    initial begin
        r = '0;
        repeat (3) step(1'b0, r, '0);
        repeat (10) step(1'b1, r, '0);
        // clean press and release on a level channel
        r[SNS_LEFT_MAIN] = 1'b1;
        repeat (20) step(1'b1, r, '0);
        r[SNS_LEFT_MAIN] = 1'b0;
        repeat (10) step(1'b1, r, '0);
        // glitchy pulses shorter than the debounce window
        for (int k = 0; k < 7; k++) begin
            r[SNS_TRAFFIC_CROSS] = (k != 3);
            step(1'b1, r, '0);
        end
        r[SNS_TRAFFIC_CROSS] = 1'b0;
        repeat (8) step(1'b1, r, '0);
        // walk request latches after release, then acknowledge
        r[SNS_WALK_MAIN] = 1'b1;
        repeat (8) step(1'b1, r, '0);
        r[SNS_WALK_MAIN] = 1'b0;
        repeat (10) step(1'b1, r, '0);
        step(1'b1, r, 5'b01000);
        repeat (3) step(1'b1, r, '0);
        // clear lands in the rise cycle, later clear while held, then re-press
        r[SNS_WALK_CROSS] = 1'b1;
        repeat (10) step(1'b1, r, {m_rise[SNS_WALK_CROSS], 4'b0});
        repeat (3) step(1'b1, r, '0);
        step(1'b1, r, 5'b10000);
        repeat (6) step(1'b1, r, '0);
        r[SNS_WALK_CROSS] = 1'b0;
        repeat (8) step(1'b1, r, '0);
        r[SNS_WALK_CROSS] = 1'b1;
        repeat (8) step(1'b1, r, '0);
        r[SNS_WALK_CROSS] = 1'b0;
        repeat (8) step(1'b1, r, '0);
        // reset with both walk latches set and channel 0 mid-count
        r = 5'b11000;
        repeat (8) step(1'b1, r, '0);
        r[SNS_LEFT_MAIN] = 1'b1;
        repeat (3) step(1'b1, r, '0);
        do_reset();
        repeat (2) step(1'b0, r, '0);
        repeat (12) step(1'b1, r, '0);
        // staggered presses on every channel, clear held on level channels
        r = '0;
        repeat (8) step(1'b1, r, '0);
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 5; k++) r[k] = (t >= 3 * k + 2) && (t < 3 * k + 20);
            step(1'b1, r, 5'b00111);
        end
        // random slow toggling with random acknowledges
        for (int t = 0; t < 1500; t++) begin
            for (int k = 0; k < 5; k++) tog[k] = ($urandom_range(7) == 0);
            r = r ^ tog;
            step(1'b1, r, 5'($urandom & $urandom));
        end
        @(posedge clk);
        #3 run = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Conditions the five raw, asynchronous traffic sensor and push-button inputs before they reach traffic_fsm.sensors[4:0].
- Synchronises each input to clk.
- Debounces each input with a per-channel stability counter.
- Latches pedestrian walk requests until the controller acknowledges them.
Sits between the board switch/button pins and the traffic controller. Also provides one-cycle rising-edge pulses for later use by stages such as a request counter.

Parameters:
N_CH, 5, number of sensor channels
DEBOUNCE_CYCLES, 500000, cycles of stable input required before the debounced level changes (10 ms at 50 MHz); legal range 1..2^CNT_W-1
CNT_W, 20, debounce counter width
LATCH_MASK, 5'b11000, per-channel select: 1 = latched request (walk main, walk cross), 0 = level pass-through (left main, left cross, traffic cross)

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous, active-low reset
raw_in  input  N_CH  unsynchronised sensor/button levels, active-high; bit map: 0 left main, 1 left cross, 2 traffic cross, 3 walk main, 4 walk cross
clear  input  N_CH  per-channel acknowledge from controller; only acts on latched channels
sensors  output  N_CH  conditioned sensor vector to traffic_fsm
rise  output  N_CH  one-cycle pulse on each debounced 0->1 transition
stable  output  N_CH  debounced level of each channel, regardless of latch mode

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset (reset_n=0, async assert, sync-release use):
  - Synchroniser flops, debounced levels, counters, latches, sensors, rise and stable all go to 0.
  - Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per channel; sync[i] lags raw_in[i] by 2 cycles.
- Debounce, per channel (all channels independent):
  - If sync==stable: counter cleared to 0.
  - Else, if counter==DEBOUNCE_CYCLES-1: stable<=sync and counter<=0.
  - Else: counter<=counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES consecutive cycles resets the count and never reaches stable.
  - Latency from a clean raw_in edge to the stable change is 2+DEBOUNCE_CYCLES cycles.
  - The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- rise[i]: high for exactly the one cycle after stable[i] goes 0->1; no pulse on 1->0.
- Level channels (LATCH_MASK[i]=0):
  - sensors[i]=stable[i], combinational from the stable register, so no added latency.
  - clear[i] is ignored.
- Latched channels (LATCH_MASK[i]=1):
  - sensors[i] is a register.
  - Set on the cycle that stable[i] rises; visible in the same cycle as rise[i].
  - Cleared on a cycle with clear[i]=1 and no simultaneous set.
  - Otherwise holds.
  - Set and clear in the same cycle: set wins, so no request is lost.
  - A button still held after clear does not re-set the latch; a new 0->1 debounced edge is required.
  - Clear while already 0: no effect.
- No other state; no handshake beyond clear. Outputs are always valid after reset release.

Decomposition:
- Shared package traffic_pkg:
  - Channel index constants SNS_LEFT_MAIN=0, SNS_LEFT_CROSS=1, SNS_TRAFFIC_CROSS=2, SNS_WALK_MAIN=3, SNS_WALK_CROSS=4.
  - N_CH.
  - Default LATCH_MASK.
  - Default DEBOUNCE_CYCLES.
- One natural sub-module: debounce_chan, containing the per-channel 2-flop synchroniser, counter, stable register and rise pulse.
  - Ports: clk, reset_n, raw, stable, rise; parameters DEBOUNCE_CYCLES and CNT_W.
  - Instantiated N_CH times by generate.
  - The latch logic stays in the top level.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 and CNT_W=3.
1. Clean press: raw_in[0] held 0->1 at cycle 10 -> stable[0]=1 and sensors[0]=1 at cycle 16; rise[0] high only in cycle 16. Release at cycle 30 -> sensors[0]=0 at cycle 36; no rise pulse.
2. Glitch rejection: raw_in[2] high for 3 cycles, low for 1, high for 3 -> stable[2], sensors[2] and rise[2] stay 0 throughout.
3. Walk latch and acknowledge: raw_in[3] pulsed long enough to debounce, then released -> sensors[3] stays 1 after stable[3] returns to 0; clear[3]=1 for one cycle -> sensors[3]=0 on the next cycle.
4. Simultaneous set and clear: drive clear[4]=1 in exactly the cycle rise[4] fires -> sensors[4]=1 and stays 1. Button held, then clear[4] pulsed -> sensors[4]=0 with no re-latch until release and re-press.
5. Reset mid-operation: assert reset_n=0 asynchronously mid-count and with sensors=5'b11000 latched -> all outputs 0 immediately, without waiting for a clk edge. After release, with raw_in unchanged and high, stable rises only after the full 2+4 cycles.
6. Independence: toggle all five raw_in bits with staggered timing -> each channel's timing matches scenario 1 independently; clear applied to level channels 0..2 has no effect.
